hazard_control_unit: RTL

Pipeline control block for the five-stage RV32I core. It sits upstream of the forwarding unit and drives the load enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It freezes the pipeline on instruction- or data-memory waits, inserts one bubble for load-use hazards that forwarding cannot cover, and squashes wrong-path instructions on taken branches and jumps. It also keeps performance counters readable by the debug path.

---
 rtl/regfilemux.sv | 16 +
 rtl/hazard_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfilemux.sv
// Writeback-select encoding shared by the decode and hazard logic.
package regfilemux;

   typedef enum logic [3:0] {
      alu_out  = 4'd0,
      br_en    = 4'd1,
      u_imm    = 4'd2,
      lw       = 4'd3,
      pc_plus4 = 4'd4,
      lb       = 4'd5,
      lbu      = 4'd6,
      lh       = 4'd7,
      lhu      = 4'd8
   } regfilemux_sel_t;

endpackage : regfilemux

// File: rtl/hazard_control_unit.sv
// Pipeline control for the five-stage RV32I core: freezes on memory waits,
// inserts a single load-use bubble, squashes wrong-path work on taken
// branches, and keeps performance counters for the debug path.
module hazard_control_unit
   import regfilemux::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned EPI_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [4:0]            id_ex_rd,
   input  regfilemux_sel_t       id_ex_regfile_sel,
   input  logic                  ex_br_taken,
   input  logic                  imem_req,
   input  logic                  imem_resp,
   input  logic                  dmem_req,
   input  logic                  dmem_resp,
   input  logic                  perf_clr,
   output logic                  load_pc,
   output logic                  load_if_id,
   output logic                  load_id_ex,
   output logic                  load_ex_mem,
   output logic                  load_mem_wb,
   output logic                  flush_if_id,
   output logic                  bubble_id_ex,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [CNT_W-1:0]      mem_stall_cnt,
   output logic [CNT_W-1:0]      lu_bubble_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [EPI_W-1:0]      stall_episodes
);

   typedef enum logic {
      RUN    = 1'b0,
      MSTALL = 1'b1
   } stall_state_t;

   stall_state_t     stall_q, stall_d;

   logic             mem_stall;
   logic             is_load;
   logic             rs1_match;
   logic             rs2_match;
   logic             lu_hazard;
   logic             take_flush;
   logic             take_bubble;
   logic             episode_start;

   logic [CNT_W-1:0] cycle_q,  cycle_d;
   logic [CNT_W-1:0] mstall_q, mstall_d;
   logic [CNT_W-1:0] lubub_q,  lubub_d;
   logic [CNT_W-1:0] flush_q,  flush_d;
   logic [EPI_W-1:0] epi_q,    epi_d;

   // Episode counter stops at all-ones instead of wrapping back to zero.
   function automatic logic [EPI_W-1:0] sat_inc(input logic [EPI_W-1:0] v);
      logic [EPI_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + EPI_W'(1);
      end
      return r;
   endfunction

   // Modulo increment for the free-running performance counters.
   function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
      return v + CNT_W'(1);
   endfunction

   // Hazard detection: memory waits and loads whose result ID needs now.
   always_comb begin
      mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
      case (id_ex_regfile_sel)
         lw, lb, lbu, lh, lhu: is_load = 1'b1;
         default:              is_load = 1'b0;
      endcase
      rs1_match = id_uses_rs1 & (id_rs1 == id_ex_rd);
      rs2_match = id_uses_rs2 & (id_rs2 == id_ex_rd);
      lu_hazard = is_load & (id_ex_rd != 5'd0) & (rs1_match | rs2_match);
   end

   // Prioritised stage enables: memory freeze beats branch squash beats
   // load-use bubble; a branch squash makes any load-use conflict moot.
   always_comb begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      flush_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      take_flush   = 1'b0;
      take_bubble  = 1'b0;
      if (mem_stall) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
      end else if (ex_br_taken) begin
         flush_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
         take_flush   = 1'b1;
      end else if (lu_hazard) begin
         load_pc      = 1'b0;
         load_if_id   = 1'b0;
         bubble_id_ex = 1'b1;
         take_bubble  = 1'b1;
      end
   end

   // Stall-tracking state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= RUN;
      end else begin
         stall_q <= stall_d;
      end
   end

   // Next stall state; an episode begins on the first stalled cycle only.
   always_comb begin
      stall_d       = stall_q;
      episode_start = 1'b0;
      case (stall_q)
         RUN: begin
            if (mem_stall) begin
               stall_d       = MSTALL;
               episode_start = 1'b1;
            end
         end
         MSTALL: begin
            if (!mem_stall) begin
               stall_d = RUN;
            end
         end
         default: stall_d = RUN;
      endcase
   end

   // Counter next values; a clear request overrides every increment.
   always_comb begin
      cycle_d  = cycle_q;
      mstall_d = mstall_q;
      lubub_d  = lubub_q;
      flush_d  = flush_q;
      epi_d    = epi_q;
      if (perf_clr) begin
         cycle_d  = '0;
         mstall_d = '0;
         lubub_d  = '0;
         flush_d  = '0;
         epi_d    = '0;
      end else begin
         cycle_d = wrap_inc(cycle_q);
         if (mem_stall) begin
            mstall_d = wrap_inc(mstall_q);
         end
         if (take_bubble) begin
            lubub_d = wrap_inc(lubub_q);
         end
         if (take_flush) begin
            flush_d = wrap_inc(flush_q);
         end
         if (episode_start) begin
            epi_d = sat_inc(epi_q);
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q  <= '0;
         mstall_q <= '0;
         lubub_q  <= '0;
         flush_q  <= '0;
         epi_q    <= '0;
      end else begin
         cycle_q  <= cycle_d;
         mstall_q <= mstall_d;
         lubub_q  <= lubub_d;
         flush_q  <= flush_d;
         epi_q    <= epi_d;
      end
   end

   assign cycle_cnt      = cycle_q;
   assign mem_stall_cnt  = mstall_q;
   assign lu_bubble_cnt  = lubub_q;
   assign flush_cnt      = flush_q;
   assign stall_episodes = epi_q;

endmodule : hazard_control_unit
